// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_reader
// Purpose  : Frame-buffer read controller; generates VGA timing from a pixel
//            tick, fetches pixels over port B and drives aligned VGA pins.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_reader #(
    parameter int C_IMG_COLS    = 640,
    parameter int C_IMG_ROWS    = 480,
    parameter int C_NB_IMG_PXLS = 19,
    parameter int C_NB_BUF      = 12,
    parameter int C_CLK_DIV     = 4,
    parameter int C_H_VISIBLE   = 640,
    parameter int C_H_FRONT     = 16,
    parameter int C_H_SYNC      = 96,
    parameter int C_H_BACK      = 48,
    parameter int C_V_VISIBLE   = 480,
    parameter int C_V_FRONT     = 10,
    parameter int C_V_SYNC      = 2,
    parameter int C_V_BACK      = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [C_NB_IMG_PXLS-1:0] addrb,
    input  logic [C_NB_BUF-1:0]      doutb,
    output logic [3:0]               vga_red,
    output logic [3:0]               vga_green,
    output logic [3:0]               vga_blue,
    output logic                     vga_hsync,
    output logic                     vga_vsync,
    output logic                     visible,
    output logic                     frame_start
);

    localparam int c_h_total = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;
    localparam int c_v_total = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);
    localparam int c_dw      = (C_CLK_DIV > 1) ? $clog2(C_CLK_DIV) : 1;

    localparam logic [c_dw-1:0] c_div_last = c_dw'(C_CLK_DIV - 1);
    localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_h_total - 1);
    localparam logic [c_vw-1:0] c_v_last   = c_vw'(c_v_total - 1);
    localparam logic [c_hw-1:0] c_h_vis    = c_hw'(C_H_VISIBLE);
    localparam logic [c_vw-1:0] c_v_vis    = c_vw'(C_V_VISIBLE);
    localparam logic [c_hw-1:0] c_h_img    = c_hw'(C_IMG_COLS);
    localparam logic [c_vw-1:0] c_v_img    = c_vw'(C_IMG_ROWS);
    localparam logic [c_hw-1:0] c_hs_first = c_hw'(C_H_VISIBLE + C_H_FRONT);
    localparam logic [c_hw-1:0] c_hs_last  = c_hw'(C_H_VISIBLE + C_H_FRONT + C_H_SYNC - 1);
    localparam logic [c_vw-1:0] c_vs_first = c_vw'(C_V_VISIBLE + C_V_FRONT);
    localparam logic [c_vw-1:0] c_vs_last  = c_vw'(C_V_VISIBLE + C_V_FRONT + C_V_SYNC - 1);

    logic [c_dw-1:0]          r_div_cnt;
    logic [c_hw-1:0]          r_h_cnt;
    logic [c_vw-1:0]          r_v_cnt;
    logic                     r_upd;
    logic [C_NB_IMG_PXLS-1:0] r_addrb;
    logic [C_NB_BUF-1:0]      r_rgb;
    logic                     r_hsync;
    logic                     r_vsync;
    logic                     r_visible;
    logic                     r_frame_start;

    logic w_tick;
    logic w_origin;
    logic w_in_img;
    logic w_in_vis;
    logic w_hs_active;
    logic w_vs_active;

    assign w_tick      = (r_div_cnt == c_div_last);
    assign w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_in_img    = (r_h_cnt < c_h_img) && (r_v_cnt < c_v_img);
    assign w_in_vis    = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
    assign w_hs_active = (r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last);
    assign w_vs_active = (r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // In-image pixels are visited in raster order, so the address of each one
    // is simply the previous in-image address plus one; outside the image the
    // last address is held, which keeps addrb inside the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd   <= 1'b0;
            r_addrb <= '0;
        end else begin
            r_upd <= w_tick;
            if (r_upd) begin
                if (w_origin) begin
                    r_addrb <= '0;
                end else if (w_in_img) begin
                    r_addrb <= r_addrb + 1'b1;
                end
            end
        end
    end

    // Sampled on the tick that leaves a pixel: doutb for that pixel has been
    // stable since two clocks after the counters moved onto it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb         <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_visible     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_origin;
            if (w_tick) begin
                r_visible <= w_in_vis;
                r_rgb     <= (w_in_vis && w_in_img) ? doutb : '0;
                r_hsync   <= ~w_hs_active;
                r_vsync   <= ~w_vs_active;
            end
        end
    end

    assign addrb       = r_addrb;
    assign vga_red     = r_rgb[11:8];
    assign vga_green   = r_rgb[7:4];
    assign vga_blue    = r_rgb[3:0];
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign visible     = r_visible;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_reader
// Purpose  : Self-checking bench; two reduced-geometry instances (full image at
//            divide-by-4, bordered image at divide-by-3) checked every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;

    localparam int H_VIS = 16;
    localparam int H_FP  = 2;
    localparam int H_SY  = 3;
    localparam int H_BP  = 2;
    localparam int V_VIS = 12;
    localparam int V_FP  = 2;
    localparam int V_SY  = 2;
    localparam int V_BP  = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SY + V_BP;
    localparam int N_PIX = H_TOT * V_TOT;

    localparam int DIV_A  = 4;
    localparam int COLS_A = 16;
    localparam int ROWS_A = 12;
    localparam int DIV_B  = 3;
    localparam int COLS_B = 10;
    localparam int ROWS_B = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [18:0] addrb_a, addrb_b;
    logic [11:0] dout_a, dout_b;
    logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        hs_a, vs_a, vis_a, fs_a, hs_b, vs_b, vis_b, fs_b;
    logic [11:0] rgb_a, rgb_b;
    assign rgb_a = {red_a, green_a, blue_a};
    assign rgb_b = {red_b, green_b, blue_b};

    logic [11:0] mem [2][256];

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;
    int cyc     = 0;
    bit armed   = 1'b0;
    int max_a   = 0;
    int max_b   = 0;

    vga_frame_reader #(
        .C_IMG_COLS(COLS_A), .C_IMG_ROWS(ROWS_A), .C_NB_IMG_PXLS(19), .C_NB_BUF(12),
        .C_CLK_DIV(DIV_A), .C_H_VISIBLE(H_VIS), .C_H_FRONT(H_FP), .C_H_SYNC(H_SY),
        .C_H_BACK(H_BP), .C_V_VISIBLE(V_VIS), .C_V_FRONT(V_FP), .C_V_SYNC(V_SY),
        .C_V_BACK(V_BP)
    ) dut_a (
        .clk(clk), .rst(rst), .addrb(addrb_a), .doutb(dout_a),
        .vga_red(red_a), .vga_green(green_a), .vga_blue(blue_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .visible(vis_a), .frame_start(fs_a)
    );

    vga_frame_reader #(
        .C_IMG_COLS(COLS_B), .C_IMG_ROWS(ROWS_B), .C_NB_IMG_PXLS(19), .C_NB_BUF(12),
        .C_CLK_DIV(DIV_B), .C_H_VISIBLE(H_VIS), .C_H_FRONT(H_FP), .C_H_SYNC(H_SY),
        .C_H_BACK(H_BP), .C_V_VISIBLE(V_VIS), .C_V_FRONT(V_FP), .C_V_SYNC(V_SY),
        .C_V_BACK(V_BP)
    ) dut_b (
        .clk(clk), .rst(rst), .addrb(addrb_b), .doutb(dout_b),
        .vga_red(red_b), .vga_green(green_b), .vga_blue(blue_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .visible(vis_b), .frame_start(fs_b)
    );

    // Frame buffer port B: one clock read latency
    always @(posedge clk) begin
        dout_a <= mem[0][addrb_a[7:0]];
        dout_b <= mem[1][addrb_b[7:0]];
    end

    // t = clocks since the last clock edge that sampled rst high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            t     <= 0;
            armed <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: actual=%h required=%h", name, t, act, exp);
        end
    endtask

    // Expected {addrb, rgb, hsync, vsync, visible, frame_start} tt clocks after reset.
    // Pixel k is entered on tick k (clock k*div); outputs show the pixel just left;
    // addrb shows the latest in-image pixel of the frame reached one clock earlier.
    function automatic logic [34:0] model(input int id, input int tt);
        int d, ic, ir, a, k, pos, h, v;
        logic [11:0] rgb;
        logic vis, hs, vs, fs;
        d  = (id == 0) ? DIV_A : DIV_B;
        ic = (id == 0) ? COLS_A : COLS_B;
        ir = (id == 0) ? ROWS_A : ROWS_B;
        a  = 0;
        if (tt > 0) begin
            pos = ((tt - 1) / d) % N_PIX;
            h   = pos % H_TOT;
            v   = pos / H_TOT;
            if (v >= ir)      a = ic * ir - 1;
            else if (h >= ic) a = v * ic + ic - 1;
            else              a = v * ic + h;
        end
        k   = tt / d;
        rgb = 12'h000;
        vis = 1'b0;
        hs  = 1'b1;
        vs  = 1'b1;
        fs  = 1'b0;
        if (k > 0) begin
            pos = (k - 1) % N_PIX;
            h   = pos % H_TOT;
            v   = pos / H_TOT;
            vis = (h < H_VIS) && (v < V_VIS);
            if (vis && h < ic && v < ir) rgb = mem[id][v * ic + h];
            hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SY);
            vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SY);
            fs  = (pos == 0) && (tt % d == 0);
        end
        return {19'(a), rgb, hs, vs, vis, fs};
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("cycle_a", {addrb_a, rgb_a, hs_a, vs_a, vis_a, fs_a}, model(0, t));
            chk("cycle_b", {addrb_b, rgb_b, hs_b, vs_b, vis_b, fs_b}, model(1, t));
            if (int'(addrb_a) > max_a) max_a = int'(addrb_a);
            if (int'(addrb_b) > max_b) max_b = int'(addrb_b);
        end
    end

    function automatic logic hs_of(input int id);
        return (id == 0) ? hs_a : hs_b;
    endfunction

    task automatic goto(input int target);
        while (t < target) @(negedge clk);
    endtask

    task automatic wait_fs(input int id, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((id == 0) ? fs_a : fs_b) == 1'b0) && n < bound);
        chk((id == 0) ? "a_fs_seen" : "b_fs_seen", 35'((id == 0) ? fs_a : fs_b), 35'd1);
    endtask

    task automatic wait_hs_fall(input int id, output int when);
        logic prev, cur;
        int   n;
        n    = 0;
        prev = hs_of(id);
        cur  = prev;
        while (n < 500) begin
            @(negedge clk);
            cur = hs_of(id);
            n++;
            if (prev && !cur) break;
            prev = cur;
        end
        when = cyc;
    endtask

    task automatic measure_line(input int id, input int exp_low, input int exp_period);
        int f1, f2, low;
        wait_hs_fall(id, f1);
        low = 0;
        while (hs_of(id) == 1'b0 && low < 500) begin
            low++;
            @(negedge clk);
        end
        wait_hs_fall(id, f2);
        chk((id == 0) ? "a_hsync_low_clks" : "b_hsync_low_clks", 35'(low), 35'(exp_low));
        chk((id == 0) ? "a_line_period" : "b_line_period", 35'(f2 - f1), 35'(exp_period));
    endtask

    initial begin
        int n, c1, c2;
        for (int id = 0; id < 2; id++) begin
            for (int i = 0; i < 256; i++) begin
                mem[id][i] = 12'(((i * 37 + 5) & 12'hFFF) | 1);
            end
        end
        mem[0][0] = 12'hF00; mem[0][COLS_A - 1] = 12'h0F0;
        mem[0][COLS_A] = 12'h00F; mem[0][COLS_A * ROWS_A - 1] = 12'hABC;
        mem[1][0] = 12'hF00; mem[1][COLS_B - 1] = 12'h0F0;
        mem[1][COLS_B] = 12'h00F; mem[1][COLS_B * ROWS_B - 1] = 12'hABC;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        chk("a_reset", {addrb_a, rgb_a, hs_a, vs_a, vis_a, fs_a}, {19'd0, 12'h000, 4'b1100});
        chk("b_reset", {addrb_b, rgb_b, hs_b, vs_b, vis_b, fs_b}, {19'd0, 12'h000, 4'b1100});

        goto(3);    chk("b_px_0_0", 35'({vis_b, fs_b, rgb_b}), 35'({2'b11, 12'hF00}));
        goto(4);    chk("a_px_0_0", 35'({vis_a, fs_a, rgb_a}), 35'({2'b11, 12'hF00}));
        goto(5);    chk("a_fs_width", 35'(fs_a), 35'd0);
        goto(30);   chk("b_px_9_0", 35'(rgb_b), 35'h0F0);
        goto(33);   chk("b_border_col", 35'({vis_b, rgb_b}), 35'({1'b1, 12'h000}));
        goto(64);   chk("a_px_15_0", 35'(rgb_a), 35'h0F0);
        goto(68);   chk("a_blank", 35'({vis_a, rgb_a}), 35'd0);
        goto(72);   chk("a_hs_before", 35'(hs_a), 35'd1);
                    chk("b_px_0_1", 35'(rgb_b), 35'h00F);
        goto(76);   chk("a_hs_first", 35'(hs_a), 35'd0);
        goto(88);   chk("a_hs_after", 35'(hs_a), 35'd1);
        goto(96);   chk("a_px_0_1", 35'(rgb_a), 35'h00F);
        goto(444);  chk("b_px_last", 35'(rgb_b), 35'hABC);
        goto(486);  chk("b_border_row", 35'({vis_b, rgb_b}), 35'({1'b1, 12'h000}));
        goto(1076); chk("a_px_last", 35'(rgb_a), 35'hABC);
        goto(1292); chk("a_vsync_line14", 35'(vs_a), 35'd0);

        measure_line(0, H_SY * DIV_A, H_TOT * DIV_A);
        measure_line(1, H_SY * DIV_B, H_TOT * DIV_B);

        wait_fs(0, 4000, n);
        c1 = cyc;
        wait_fs(0, 4000, n);
        c2 = cyc;
        chk("a_frame_period", 35'(c2 - c1), 35'(N_PIX * DIV_A));

        // Pulse reset while dut_a is on line 5, pixel 7
        goto(3800);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("a_midreset", {addrb_a, rgb_a, hs_a, vs_a, vis_a, fs_a}, {19'd0, 12'h000, 4'b1100});
        chk("b_midreset", {addrb_b, rgb_b, hs_b, vs_b, vis_b, fs_b}, {19'd0, 12'h000, 4'b1100});
        wait_fs(0, 20, n);
        chk("a_fs_after_reset", 35'(n), 35'(DIV_A));
        chk("a_addr_after_reset", 35'(addrb_a), 35'd0);

        goto(2000);
        chk("a_addr_max", 35'(max_a), 35'(COLS_A * ROWS_A - 1));
        chk("b_addr_max", 35'(max_b), 35'(COLS_B * ROWS_B - 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, t=%0d", t);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Read-side controller for the dual-port frame buffer.
- Generates 640x480@60 VGA timing from the system clock using an internal pixel-tick divider.
- Drives the buffer read address (port B), takes the 12-bit {R,G,B} word returned one clock later, and drives registered, aligned VGA pins.
- Visible pixels outside the stored image area are shown black.

Parameters:
- c_img_cols, 640, stored image width in pixels (must be ≤ c_h_visible)
- c_img_rows, 480, stored image height in lines (must be ≤ c_v_visible)
- c_nb_img_pxls, 19, buffer address width
- c_nb_buf, 12, buffer word width, packed {R[11:8],G[7:4],B[3:0]}
- c_clk_div, 4, system clocks per pixel (must be ≥ 3)
- c_h_visible, 640, c_h_front, 16, c_h_sync, 96, c_h_back, 48 (total 800)
- c_v_visible, 480, c_v_front, 10, c_v_sync, 2, c_v_back, 33 (total 525)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addrb  out  c_nb_img_pxls  frame buffer read address
- doutb  in  c_nb_buf  frame buffer read data, valid 1 clk after addrb
- vga_red  out  4  red
- vga_green  out  4  green
- vga_blue  out  4  blue
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- visible  out  1  high while the output pixel is inside the 640x480 active area
- frame_start  out  1  one-clk pulse when the counters enter pixel (0,0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: div_cnt=0, h_cnt=0, v_cnt=0, addrb=0, rgb=0, vga_hsync=1, vga_vsync=1, visible=0, frame_start=0. Asserting rst mid-frame restarts at (0,0) on the next clk with these values.
- Pixel tick:
  - div_cnt counts 0..c_clk_div-1 and wraps.
  - tick=1 when div_cnt==c_clk_div-1.
  - The first tick after reset release occurs c_clk_div clks after the last reset cycle.
- Counters (update on tick only):
  - h_cnt 0..799, wraps to 0.
  - v_cnt increments on h_cnt wrap, 0..524, wraps to 0.
- frame_start: asserted for exactly one clk, on the clk where the counters become (0,0).
- Address (registered on the clk after the counters change):
  - If h_cnt<c_img_cols and v_cnt<c_img_rows: addrb = v_cnt*c_img_cols + h_cnt.
  - Otherwise addrb holds its value.
  - A running address register (reset at (0,0), +1 per in-image pixel) is the required implementation; no multiplier.
  - Last in-image pixel (default): addrb = 307199.
- Data alignment: doutb is valid 2 clks after the counter update. c_clk_div ≥ 3 guarantees it is stable before the next tick.
- Output stage (registered on tick): outputs describe the position the counters held during the previous pixel period, so all VGA outputs lag the counters by exactly 1 pixel (c_clk_div clks) and are mutually aligned.
  - visible = (h<c_h_visible && v<c_v_visible)
  - rgb = doutb fields if visible && h<c_img_cols && v<c_img_rows, else 0
  - vga_hsync = 0 for h in [656,751], else 1
  - vga_vsync = 0 for v in [490,491], else 1
- No glitches: every output comes straight from a flop.
- Frame period: 800*525*c_clk_div clks = 1,680,000 at default.
- addrb is never outside 0..c_img_cols*c_img_rows-1.

Test Plan:
1. Reset: hold rst 5 clks, release -> addrb=0, rgb=0, hsync=vsync=1, visible=0. First frame_start pulse occurs; every later frame_start is exactly 1,680,000 clks apart; pulse width is 1 clk.
2. Line timing: count ticks -> vga_hsync low for exactly 96 pixels per line, starting 656 pixels after the line's first visible output. Line period is 3200 clks. vga_vsync is low for lines 490–491 only.
3. Data mapping with a RAM model (1-clk read latency):
   - preload addr 0=0xF00, addr 639=0x0F0, addr 640=0x00F, addr 307199=0xABC
   - required: pixel (0,0) shows R=F,G=0,B=0; (639,0) shows G=F; (0,1) shows B=F; (639,479) shows A,B,C
   - in blanking, rgb=0 and visible=0
4. Border, with c_img_cols=320, c_img_rows=240 and RAM filled with 0xFFF:
   - pixels h≥320 or v≥240 inside the active area output rgb=0 with visible=1
   - addrb max = 76799, and addrb never exceeds it
5. Reset mid-frame: assert rst for 1 clk at line 300, h=100 -> outputs return to reset values next clk. After release, timing restarts from (0,0): next frame_start at c_clk_div clks, addrb=0.
6. Divider: run c_clk_div=3 -> line period 2400 clks and pixel data is still correct. This confirms doutb is sampled after the 2-clk address/data latency.
